// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control unit: instruction decode, Moore sequencing FSM, condition evaluation on an internal NZCV register.
// Latency: data processing 4 cycles, LDR 5, STR 4, B 3; every output is combinational on state, Instr and flags.
// No backpressure: the FSM advances every clock; reset forces all write enables low immediately.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  state_dbg
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic [3:0] state, state_nxt;
    logic [3:0] flags;
    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic       i_bit, s_bit;
    logic       next_pc, branch, reg_w, mem_w, ir_write;
    logic [1:0] alu_dec, flag_w;
    logic       no_write, cond_ex, pcs, in_exec;
    logic       unused_instr;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign i_bit = Instr[25];
    assign cmd   = Instr[24:21];
    assign s_bit = Instr[20];
    assign rd    = Instr[15:12];
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    assign in_exec   = (state == S_EXECR) || (state == S_EXECI);
    assign state_dbg = state;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next-state sequencing; unused encodings recover to FETCH.
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_nxt = i_bit ? S_EXECI : S_EXECR;
                    2'b01:   state_nxt = S_MEMADR;
                    2'b10:   state_nxt = S_BRANCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = s_bit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_EXECR:  state_nxt = S_ALUWB;
            S_EXECI:  state_nxt = S_ALUWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // ALU command decode; NoWrite is state-independent so it still gates the ALUWB write.
    always_comb begin
        alu_dec  = 2'b00;
        flag_w   = 2'b00;
        no_write = 1'b0;
        if (op == 2'b00) begin
            case (cmd)
                4'b0100: begin alu_dec = 2'b00; flag_w = s_bit ? 2'b11 : 2'b00; end
                4'b0010: begin alu_dec = 2'b01; flag_w = s_bit ? 2'b11 : 2'b00; end
                4'b0000: begin alu_dec = 2'b10; flag_w = s_bit ? 2'b10 : 2'b00; end
                4'b1100: begin alu_dec = 2'b11; flag_w = s_bit ? 2'b10 : 2'b00; end
                4'b1010: begin alu_dec = 2'b01; flag_w = 2'b11; no_write = 1'b1; end
                default: begin alu_dec = 2'b00; flag_w = 2'b00; no_write = 1'b1; end
            endcase
        end
    end

    // Moore outputs per state, before condition gating.
    always_comb begin
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_write   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        ImmSrc     = op;
        RegSrc     = {op == 2'b01, op == 2'b10};
        case (state)
            S_FETCH:  begin ir_write = 1'b1; next_pc = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
            S_DECODE: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
            S_MEMADR: begin ALUSrcB = 2'b01; end
            S_MEMRD:  begin AdrSrc = 1'b1; end
            S_MEMWB:  begin ResultSrc = 2'b10; reg_w = 1'b1; end
            S_MEMWR:  begin AdrSrc = 1'b1; mem_w = 1'b1; end
            S_EXECR:  begin ALUControl = alu_dec; end
            S_EXECI:  begin ALUSrcB = 2'b01; ALUControl = alu_dec; end
            S_ALUWB:  begin ResultSrc = 2'b01; reg_w = 1'b1; end
            S_BRANCH: begin ALUSrcB = 2'b01; branch = 1'b1; end
            default:  begin end
        endcase
    end

    // Condition evaluation against the stored NZCV; 1111 never executes.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // NZCV register: N,Z and C,V halves load independently in the execute cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (in_exec && cond_ex) begin
            if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
            if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign pcs      = branch | (reg_w & (rd == 4'd15));
    assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex));
    assign RegWrite = ~reset & reg_w & cond_ex & ~no_write & ~branch;
    assign MemWrite = ~reset & mem_w & cond_ex;
    assign IRWrite  = ~reset & ir_write;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions, mid-store reset, then random instruction stream.
// Reference model works per instruction class (state walk list, per-phase expectations, architectural NZCV).
// Outputs sampled 1ns after the falling edge; inputs change on the falling edge.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  state_dbg;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [3:0] m_flags;   // model N,Z,C,V

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ARM condition field against model flags
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;            1: return !z;
            2: return cy;           3: return !cy;
            4: return n;            5: return !n;
            6: return v;            7: return !v;
            8: return cy && !z;     9: return !cy || z;
            10: return n == v;      11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1;
            default: return 0;
        endcase
    endfunction

    // Per-class state walk; -1 marks the end
    function automatic int walk(input logic [31:0] ins, input int k);
        int dpr[4] = '{0, 1, 6, 8};
        int dpi[4] = '{0, 1, 7, 8};
        int ldr[5] = '{0, 1, 2, 3, 4};
        int str[4] = '{0, 1, 2, 5};
        int br[3]  = '{0, 1, 9};
        int und[2] = '{0, 1};
        case (ins[27:26])
            2'b00: if (k < 4) return ins[25] ? dpi[k] : dpr[k];
            2'b01: if (ins[20]) begin if (k < 5) return ldr[k]; end
                   else if (k < 4) return str[k];
            2'b10: if (k < 3) return br[k];
            default: if (k < 2) return und[k];
        endcase
        return -1;
    endfunction

    // Data-processing command semantics: {known, alu op, flag mask, suppresses write}
    task automatic dp_info(input logic [31:0] ins, output bit known, output int alu,
                           output int fmask, output bit nowr);
        bit s = ins[20];
        known = 1; nowr = 0; alu = 0; fmask = 0;
        case (ins[24:21])
            4'b0100: begin alu = 0; fmask = s ? 3 : 0; end
            4'b0010: begin alu = 1; fmask = s ? 3 : 0; end
            4'b0000: begin alu = 2; fmask = s ? 2 : 0; end
            4'b1100: begin alu = 3; fmask = s ? 2 : 0; end
            4'b1010: begin alu = 1; fmask = 3; nowr = 1; end
            default: begin known = 0; nowr = 1; end
        endcase
    endtask

    // Check one cycle of an instruction, then advance one clock updating model flags
    task automatic step(input logic [31:0] ins, input int st);
        bit ok, known, nowr, rd15, pcw, mw, rw, irw, adr;
        int alu, fm, sa, sb, rs, aluc;
        logic [1:0] op;
        logic [12:0] mux;
        op   = ins[27:26];
        ok   = cond_pass(ins[31:28], m_flags);
        rd15 = (ins[15:12] == 4'hF);
        dp_info(ins, known, alu, fm, nowr);
        pcw = 0; mw = 0; rw = 0; irw = 0; adr = 0; sa = 0; sb = 0; rs = 0; aluc = 0;
        case (st)
            0: begin pcw = 1; irw = 1; sa = 1; sb = 2; end
            1: begin sa = 1; sb = 2; end
            2: sb = 1;
            3: adr = 1;
            4: begin rs = 2; rw = ok; pcw = ok && rd15; end
            5: begin adr = 1; mw = ok; end
            6: aluc = alu;
            7: begin sb = 1; aluc = alu; end
            8: begin rs = 1; rw = ok && !nowr; pcw = ok && rd15; end
            9: begin sb = 1; pcw = ok; end
            default: ;
        endcase
        mux = {adr, op == 2'b01, op == 2'b10, sa[1:0], sb[1:0], rs[1:0], op, aluc[1:0]};
        #1;
        chk($sformatf("state[%08h]", ins), {28'd0, state_dbg}, st);
        chk($sformatf("writes[%08h st%0d]", ins, st),
            {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, {28'd0, pcw, mw, rw, irw});
        chk($sformatf("mux[%08h st%0d]", ins, st),
            {19'd0, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl}, {19'd0, mux});
        @(posedge clk);
        if ((st == 6 || st == 7) && ok) begin
            if (fm[1]) m_flags[3:2] = ALUFlags[3:2];
            if (fm[0]) m_flags[1:0] = ALUFlags[1:0];
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af);
        Instr = ins;
        ALUFlags = af;
        for (int k = 0; walk(ins, k) >= 0; k++) step(ins, walk(ins, k));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [3:0] cmds[6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0111};
        r = $urandom;
        if ($urandom_range(0, 1) == 0) r[31:28] = 4'b1110;
        if (r[27:26] == 2'b00) begin
            r[24:21] = cmds[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) r[24:21] = 4'($urandom);
        end
        if ($urandom_range(0, 5) == 0) r[15:12] = 4'hF;
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        Instr = 32'hE0802001;
        ALUFlags = 4'b0000;
        m_flags = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", {28'd0, state_dbg}, 0);
        chk("reset_writes", {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 0);
        chk("reset_mux", {19'd0, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl},
            {19'd0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00});
        @(negedge clk);
        reset = 1'b0;

        run_instr(32'hE0802001, 4'b1111);   // ADD R2,R0,R1, flags must stay 0000
        run_instr(32'h0A000002, 4'b0000);   // BEQ with Z=0: not taken
        run_instr(32'hE2533001, 4'b0100);   // SUBS R3,R3,#1 -> Z=1
        run_instr(32'h0A000002, 4'b0000);   // BEQ taken
        run_instr(32'hE5901004, 4'b0000);   // LDR R1,[R0,#4]
        run_instr(32'hE5801008, 4'b0000);   // STR R1,[R0,#8]
        run_instr(32'hE1500001, 4'b0110);   // CMP R0,R1 -> flags 0110
        run_instr(32'h1A000002, 4'b0000);   // BNE: Z=1 so not taken

        // Reset asserted while a store is in MEMWR
        Instr = 32'hE5801008;
        for (int k = 0; k < 3; k++) step(Instr, walk(Instr, k));
        #1;
        chk("memwr_strobe", {31'd0, MemWrite}, 1);
        reset = 1'b1;
        #1;
        chk("abort_memwrite", {31'd0, MemWrite}, 0);
        chk("abort_state", {28'd0, state_dbg}, 0);
        @(negedge clk);
        reset = 1'b0;
        m_flags = 4'b0000;
        run_instr(32'h0A000002, 4'b0000);   // BEQ after reset: flags cleared, not taken
        run_instr(32'h1A000002, 4'b0000);   // BNE after reset: taken

        for (int n = 0; n < 300; n++) run_instr(rand_instr(), 4'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
